ddc_backend: RTL and testbench
==============================

DDC_BACKEND -- requirements
Module: ddc_backend

Interface
REQ-001 SHALL have parameter CSZ, default 21, meaning CIC output width.
REQ-002 SHALL have parameter OSZ, default 16, meaning output sample width; CSZ > OSZ.
REQ-003 SHALL have parameter SHW, default 3, meaning gain-shift control width.
REQ-004 SHALL have parameter RSZ, default 16, meaning decimation-rate word width.
REQ-005 SHALL have parameter DEPTH, default 8, meaning output FIFO depth; power of two, at least 2.
REQ-006 SHALL have parameter WLOG, default 7, meaning log2 of the saturation-statistics window in clocks.
REQ-007 Port clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-008 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 Port rate, input, RSZ bits: divider reload value; CIC enable period is rate+1 clocks.
REQ-010 Port ena_cic, output, 1 bit: CIC decimation strobe.
REQ-011 Port cic_v, input, 1 bit: CIC output valid, one sample pair per high cycle.
REQ-012 Port cic_i / cic_q, input, CSZ bits signed each: CIC I/Q data.
REQ-013 Port cic_shf, input, SHW bits: left-shift gain, 0..2^SHW-1.
REQ-014 Port out_ready, input, 1 bit: downstream accept.
REQ-015 Port out_valid, output, 1 bit: FIFO head valid.
REQ-016 Port i_out / q_out, output, OSZ bits signed each: FIFO head data.
REQ-017 Port fifo_lvl, output, clog2(DEPTH)+1 bits: FIFO occupancy.
REQ-018 Port ovf, output, 1 bit: sticky overflow flag.
REQ-019 Port ovf_clr, input, 1 bit: clears ovf.
REQ-020 Port sathld, output, WLOG+1 bits: saturated-sample count of the last window.

Function
REQ-021 Divider: dcnt==0 -> dcnt<=rate, ena_cic<=1; else dcnt<=dcnt-1, ena_cic<=0; rate change takes effect at next reload; rate=0 -> ena_cic high every cycle after the first.
REQ-022 Stage 1, registered: sh = cic_x <<< cic_shf, width CSZ+2^SHW-1; v1<=cic_v.
REQ-023 Stage 2, registered: take bits [top:CSZ-OSZ] of sh and saturate to OSZ signed (max 2^(OSZ-1)-1, min -2^(OSZ-1)); flag on I or Q saturation; v2<=v1.
REQ-024 FIFO write on v2; accepted if not full, or if full and a read occurs the same cycle.
REQ-025 v2 while full without a read -> sample pair dropped, ovf<=1; FIFO contents unchanged.
REQ-026 ovf_clr and an overflow in the same cycle -> ovf stays 1.
REQ-027 First-word-fall-through: out_valid = (fifo_lvl != 0); i_out/q_out show the head; pop on out_valid & out_ready.
REQ-028 Latency: cic_v at cycle n -> written at edge ending cycle n+2 -> out_valid at n+3 when the FIFO was empty.
REQ-029 Write into an empty FIFO with out_ready high -> no pop that cycle; pop next cycle.
REQ-030 Pointers wrap modulo DEPTH; fifo_lvl ranges 0..DEPTH.
REQ-031 Stats: free-running WLOG-bit window counter; satsum accumulates v2&flag; at counter all-ones, sathld<=satsum+current event and satsum<=0.

Reset
REQ-032 On reset: dcnt=0, ena_cic=0, v1=v2=0, FIFO empty (fifo_lvl=0, out_valid=0), i_out=q_out=0, ovf=0, window counter=0, satsum=0, sathld=0.
REQ-033 Reset mid-operation discards all pipeline and FIFO contents on the next edge; pipeline data registers need no reset.

Configuration
REQ-034 Macro DDC_SATSTAT_EN defined: REQ-031 implemented.
REQ-035 Macro DDC_SATSTAT_EN undefined: stats logic omitted, sathld constant 0; saturation itself (REQ-023) is retained.

Verification
REQ-036 rate=3, reset released -> ena_cic pulses every 4 clocks; change to rate=1 -> period 2 after the current countdown ends.
REQ-037 Defaults, cic_i=1024, cic_q=-1024, shf=0, one cic_v -> out_valid 3 cycles later, i_out=32, q_out=-32; shf=3 -> 256/-256.
REQ-038 cic_i=1048575, shf=1 -> i_out=32767; cic_q=-1048576, shf=0 -> q_out=-32768; with DDC_SATSTAT_EN, 5 saturated pairs in one window -> sathld=5 at window end.
REQ-039 out_ready=0, 10 cic_v pulses -> fifo_lvl=8, ovf=1, first 8 pairs retained in order; ovf_clr -> ovf=0.
REQ-040 FIFO full, out_ready=1, simultaneous write -> fifo_lvl stays 8, no overflow; reset asserted with FIFO at level 5 -> fifo_lvl=0 and out_valid=0 next cycle.

Source files
------------

// File: rtl/ddc_backend.sv
// ddc_backend: DDC back end between the CIC decimator and the sample consumer.
//   - rate divider producing the CIC decimation strobe
//   - two-stage gain shift / truncate / saturate pipeline for the I/Q pair
//   - first-word-fall-through output FIFO with a sticky overflow flag
//   - optional saturation statistics over a 2^WLOG clock window, built only
//     when the macro DDC_SATSTAT_EN is defined (otherwise sathld reads 0)
module ddc_backend #(
  parameter int CSZ   = 21,
  parameter int OSZ   = 16,
  parameter int SHW   = 3,
  parameter int RSZ   = 16,
  parameter int DEPTH = 8,
  parameter int WLOG  = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [RSZ-1:0]            rate,
  output logic                      ena_cic,
  input  logic                      cic_v,
  input  logic signed [CSZ-1:0]     cic_i,
  input  logic signed [CSZ-1:0]     cic_q,
  input  logic [SHW-1:0]            cic_shf,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic signed [OSZ-1:0]     i_out,
  output logic signed [OSZ-1:0]     q_out,
  output logic [$clog2(DEPTH):0]    fifo_lvl,
  output logic                      ovf,
  input  logic                      ovf_clr,
  output logic [WLOG:0]             sathld
);

  // Shifted width holds the full input shifted by the largest gain.
  localparam int SHZ = CSZ + (1 << SHW) - 1;
  // Width left after dropping the CSZ-OSZ low bits.
  localparam int TW  = SHZ - (CSZ - OSZ);
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;

  // ---------------------------------------------------------------------
  // Saturation helpers
  // ---------------------------------------------------------------------
  // Value fits in OSZ signed bits only if all bits above the OSZ-1 sign
  // position are copies of it.
  function automatic logic sat_hit(input logic [TW-OSZ:0] top);
    return !((top == '0) || (top == '1));
  endfunction

  function automatic logic signed [OSZ-1:0] sat_val(input logic signed [TW-1:0] t);
    if (sat_hit(t[TW-1:OSZ-1])) begin
      if (t[TW-1]) return {1'b1, {(OSZ-1){1'b0}}};
      else         return {1'b0, {(OSZ-1){1'b1}}};
    end
    return t[OSZ-1:0];
  endfunction

  // ---------------------------------------------------------------------
  // Rate divider
  // ---------------------------------------------------------------------
  logic [RSZ-1:0] dcnt_q, dcnt_d;
  logic           ena_q,  ena_d;

  // Reload from rate when the count reaches zero and strobe the CIC.
  always_comb begin
    dcnt_d = dcnt_q;
    ena_d  = 1'b0;
    if (dcnt_q == '0) begin
      dcnt_d = rate;
      ena_d  = 1'b1;
    end else begin
      dcnt_d = dcnt_q - RSZ'(1);
    end
  end

  assign ena_cic = ena_q;

  // ---------------------------------------------------------------------
  // Stage 1: sign-extend and apply the gain shift
  // ---------------------------------------------------------------------
  logic signed [SHZ-1:0] ext_i, ext_q;
  logic signed [SHZ-1:0] sh_i_q, sh_q_q, sh_i_d, sh_q_d;
  logic                  v1_q, v1_d;

  // Gain shift on the sign-extended CIC sample pair.
  always_comb begin
    ext_i  = {{(SHZ-CSZ){cic_i[CSZ-1]}}, cic_i};
    ext_q  = {{(SHZ-CSZ){cic_q[CSZ-1]}}, cic_q};
    sh_i_d = ext_i <<< cic_shf;
    sh_q_d = ext_q <<< cic_shf;
    v1_d   = cic_v;
  end

  // ---------------------------------------------------------------------
  // Stage 2: drop low bits and saturate to OSZ
  // ---------------------------------------------------------------------
  logic signed [TW-1:0]  tr_i, tr_q;
  logic signed [OSZ-1:0] s2_i_q, s2_q_q, s2_i_d, s2_q_d;
  logic                  v2_q, v2_d;
`ifdef DDC_SATSTAT_EN
  logic                  flag_q, flag_d;
`endif

  // Truncate by arithmetic shift and clamp to the output range.
  always_comb begin
    tr_i   = TW'(sh_i_q >>> (CSZ - OSZ));
    tr_q   = TW'(sh_q_q >>> (CSZ - OSZ));
    s2_i_d = sat_val(tr_i);
    s2_q_d = sat_val(tr_q);
    v2_d   = v1_q;
`ifdef DDC_SATSTAT_EN
    flag_d = sat_hit(tr_i[TW-1:OSZ-1]) | sat_hit(tr_q[TW-1:OSZ-1]);
`endif
  end

  // ---------------------------------------------------------------------
  // Output FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------
  logic signed [OSZ-1:0] fifo_i_q [DEPTH];
  logic signed [OSZ-1:0] fifo_q_q [DEPTH];
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]         lvl_q,    lvl_d;
  logic                  ovf_q,    ovf_d;
  logic                  empty, full, pop, push, drop;

  // A full FIFO still accepts a write when the head is popped in the same
  // cycle; a write into an empty FIFO cannot pop because the head is not
  // yet visible.
  always_comb begin
    empty    = (lvl_q == '0);
    full     = (lvl_q == LW'(DEPTH));
    pop      = !empty && out_ready;
    push     = v2_q && (!full || pop);
    drop     = v2_q && full && !pop;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    lvl_d    = lvl_q;
    if (push && !pop)      lvl_d = lvl_q + LW'(1);
    else if (pop && !push) lvl_d = lvl_q - LW'(1);
    ovf_d    = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // Head is forced to zero while empty so the outputs are defined at reset
  // without clearing the storage array.
  always_comb begin
    out_valid = !empty;
    fifo_lvl  = lvl_q;
    ovf       = ovf_q;
    i_out     = '0;
    q_out     = '0;
    if (!empty) begin
      i_out = fifo_i_q[rd_ptr_q];
      q_out = fifo_q_q[rd_ptr_q];
    end
  end

  // ---------------------------------------------------------------------
  // Saturation statistics
  // ---------------------------------------------------------------------
`ifdef DDC_SATSTAT_EN
  localparam int SW = WLOG + 1;
  logic [WLOG-1:0] wcnt_q,   wcnt_d;
  logic [SW-1:0]   satsum_q, satsum_d;
  logic [SW-1:0]   sathld_q, sathld_d;
  logic            sat_ev;

  // Count saturated pairs at the FIFO input; publish and restart each window.
  always_comb begin
    sat_ev   = v2_q && flag_q;
    wcnt_d   = wcnt_q + WLOG'(1);
    sathld_d = sathld_q;
    satsum_d = satsum_q + SW'(sat_ev);
    if (wcnt_q == '1) begin
      sathld_d = satsum_q + SW'(sat_ev);
      satsum_d = '0;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q   <= '0;
      satsum_q <= '0;
      sathld_q <= '0;
    end else begin
      wcnt_q   <= wcnt_d;
      satsum_q <= satsum_d;
      sathld_q <= sathld_d;
    end
  end

  assign sathld = sathld_q;
`else
  assign sathld = '0;
`endif

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  // Control state: divider, valid pipeline, FIFO pointers and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      dcnt_q   <= '0;
      ena_q    <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      lvl_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      dcnt_q   <= dcnt_d;
      ena_q    <= ena_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      lvl_q    <= lvl_d;
      ovf_q    <= ovf_d;
    end
  end

  // Pipeline data registers; qualified by the valid pipeline, no reset.
  always_ff @(posedge clk) begin
    sh_i_q <= sh_i_d;
    sh_q_q <= sh_q_d;
    s2_i_q <= s2_i_d;
    s2_q_q <= s2_q_d;
`ifdef DDC_SATSTAT_EN
    flag_q <= flag_d;
`endif
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_i_q[wr_ptr_q] <= s2_i_q;
      fifo_q_q[wr_ptr_q] <= s2_q_q;
    end
  end

endmodule

// File: tb/tb_ddc_backend.sv
// Self-checking bench for ddc_backend: directed steps followed by a random
// phase, all checked against a queue-based arithmetic model of the block.
module tb_ddc_backend;

  localparam int DEPTH = 8;
  localparam int WIN   = 128;

  logic               clk = 1'b0;
  logic               reset;
  logic [15:0]        rate;
  logic               ena_cic;
  logic               cic_v;
  logic signed [20:0] cic_i, cic_q;
  logic [2:0]         shf;
  logic               out_ready;
  logic               out_valid;
  logic signed [15:0] i_out, q_out;
  logic [3:0]         fifo_lvl;
  logic               ovf;
  logic               ovf_clr;
  logic [7:0]         sathld;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int mq_i[$];
  int mq_q[$];
  bit p1_v, p2_v, p2_hit;
  int p1_i, p1_q, p1_s, p2_i, p2_q;
  bit m_ovf;
  int m_wcnt, m_satsum, m_sathld;

  ddc_backend #(
    .CSZ(21), .OSZ(16), .SHW(3), .RSZ(16), .DEPTH(DEPTH), .WLOG(7)
  ) dut (
    .clk(clk), .reset(reset), .rate(rate), .ena_cic(ena_cic),
    .cic_v(cic_v), .cic_i(cic_i), .cic_q(cic_q), .cic_shf(shf),
    .out_ready(out_ready), .out_valid(out_valid), .i_out(i_out), .q_out(q_out),
    .fifo_lvl(fifo_lvl), .ovf(ovf), .ovf_clr(ovf_clr), .sathld(sathld)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // x * 2^s, divided by 32 rounding toward minus infinity, clamped to 16 bits
  function automatic int scale(input int x, input int s, output bit hit);
    longint v, f;
    v = longint'(x) * (longint'(1) << s);
    if (v >= 0) f = v / 32;
    else        f = -((-v + 31) / 32);
    hit = 1'b0;
    if (f > 32767)  begin f = 32767;  hit = 1'b1; end
    if (f < -32768) begin f = -32768; hit = 1'b1; end
    return int'(f);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock with the current inputs, clock the DUT,
  // then compare all observable outputs.
  task automatic step();
    bit rd, acc, drop, ev, hi, hq;
    int ni, nq;
    if (reset) begin
      mq_i.delete(); mq_q.delete();
      p1_v = 0; p2_v = 0; m_ovf = 0;
      m_wcnt = 0; m_satsum = 0; m_sathld = 0;
    end else begin
      rd   = (mq_i.size() != 0) && out_ready;
      ev   = p2_v && p2_hit;
      acc  = p2_v && ((mq_i.size() < DEPTH) || rd);
      drop = p2_v && !acc;
      if (rd) begin
        void'(mq_i.pop_front());
        void'(mq_q.pop_front());
      end
      if (acc) begin
        mq_i.push_back(p2_i);
        mq_q.push_back(p2_q);
      end
      if (drop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      if (m_wcnt == WIN - 1) begin
        m_sathld = m_satsum + int'(ev);
        m_satsum = 0;
      end else begin
        m_satsum += int'(ev);
      end
      m_wcnt = (m_wcnt + 1) % WIN;
      ni = scale(p1_i, p1_s, hi);
      nq = scale(p1_q, p1_s, hq);
      p2_v = p1_v; p2_i = ni; p2_q = nq; p2_hit = hi | hq;
      p1_v = cic_v; p1_i = int'(cic_i); p1_q = int'(cic_q); p1_s = int'(shf);
    end
    @(posedge clk);
    #1;
    check("fifo_lvl", int'(fifo_lvl), mq_i.size());
    check("out_valid", int'(out_valid), int'(mq_i.size() != 0));
    check("i_out", int'(i_out), (mq_i.size() != 0) ? mq_i[0] : 0);
    check("q_out", int'(q_out), (mq_q.size() != 0) ? mq_q[0] : 0);
    check("ovf", int'(ovf), int'(m_ovf));
`ifdef DDC_SATSTAT_EN
    check("sathld", int'(sathld), m_sathld);
`else
    check("sathld", int'(sathld), 0);
`endif
  endtask

  task automatic send(input int xi, input int xq, input int s);
    cic_v = 1'b1;
    cic_i = 21'(xi);
    cic_q = 21'(xq);
    shf   = 3'(s);
    step();
    cic_v = 1'b0;
  endtask

  initial begin
    int pulses[$];
    reset = 1'b1; rate = 16'd3; cic_v = 1'b0; cic_i = '0; cic_q = '0;
    shf = '0; out_ready = 1'b0; ovf_clr = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_ena", int'(ena_cic), 0);

    // Divider: period 4 at rate=3, then period 2 after switching to rate=1
    reset = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (ena_cic) begin
        pulses.push_back(c);
        if (pulses.size() == 3) rate = 16'd1;
      end
    end
    check("div_npulses", int'(pulses.size() >= 6), 1);
    if (pulses.size() >= 6) begin
      check("div_first", pulses[0], 1);
      check("div_p01", pulses[1] - pulses[0], 4);
      check("div_p12", pulses[2] - pulses[1], 4);
      check("div_p23", pulses[3] - pulses[2], 4);
      check("div_p34", pulses[4] - pulses[3], 2);
      check("div_p45", pulses[5] - pulses[4], 2);
    end

    // Basic gain and latency
    send(1024, -1024, 0);
    step();
    check("lat_not_yet", int'(out_valid), 0);
    step();
    check("lat_valid", int'(out_valid), 1);
    check("g0_i", int'(i_out), 32);
    check("g0_q", int'(q_out), -32);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    send(1024, -1024, 3);
    repeat (2) step();
    check("g3_i", int'(i_out), 256);
    check("g3_q", int'(q_out), -256);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Saturation boundaries
    send(1048575, 0, 1);
    repeat (2) step();
    check("sat_pos", int'(i_out), 32767);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    send(0, -1048576, 0);
    repeat (2) step();
    check("sat_neg", int'(q_out), -32768);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Five saturated pairs inside the first window after reset
    reset = 1'b1; step(); reset = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) send(1048575, 100, 1);
    repeat (125) step();
`ifdef DDC_SATSTAT_EN
    check("sathld_5", int'(sathld), 5);
`else
    check("sathld_off", int'(sathld), 0);
`endif
    out_ready = 1'b0;

    // Overflow: 10 writes into an 8-deep FIFO with no reads
    for (int k = 1; k <= 10; k++) send(k * 32, -k * 32, 0);
    repeat (2) step();
    check("ovf_lvl", int'(fifo_lvl), 8);
    check("ovf_set", int'(ovf), 1);
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check("ovf_order_i", int'(i_out), k);
      check("ovf_order_q", int'(q_out), -k);
      step();
    end
    out_ready = 1'b0;
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    check("ovf_clr", int'(ovf), 0);

    // Full FIFO with a simultaneous read and write keeps its level
    for (int c = 0; c < 14; c++) begin
      cic_v = (c < 12);
      cic_i = 21'(c * 64);
      cic_q = 21'(-c * 64);
      shf = '0;
      out_ready = (c >= 10);
      step();
      if (c >= 10) begin
        check("full_rw_lvl", int'(fifo_lvl), 8);
        check("full_rw_ovf", int'(ovf), 0);
      end
    end
    cic_v = 1'b0;
    repeat (10) step();
    out_ready = 1'b0;

    // Reset with the FIFO at level 5
    for (int k = 0; k < 5; k++) send(k * 100, k * 100, 2);
    repeat (3) step();
    check("lvl5", int'(fifo_lvl), 5);
    reset = 1'b1; step(); reset = 1'b0;
    check("rst_lvl", int'(fifo_lvl), 0);
    check("rst_valid", int'(out_valid), 0);

    // Random traffic
    for (int c = 0; c < 700; c++) begin
      cic_v     = ($urandom_range(0, 9) < 6);
      cic_i     = 21'($urandom);
      cic_q     = 21'($urandom);
      if ($urandom_range(0, 3) == 0) cic_i = 21'($urandom_range(0, 4095));
      shf       = 3'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      ovf_clr   = ($urandom_range(0, 19) == 0);
      rate      = 16'($urandom_range(0, 5));
      reset     = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0; cic_v = 1'b0; ovf_clr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
